// File: rtl/alu_rf_pkg.sv
// Shared definitions for the CR-16 execute stage: opcodes, flag bit positions, FSM states.
// The multiplier state is only used when ALU_RF_MUL_EN is defined.
package alu_rf_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_CMP = 4'd5,
      OP_MOV = 4'd6,
      OP_LSH = 4'd7,
      OP_MUL = 4'd8
   } op_e;

   localparam int FLAG_N = 4;
   localparam int FLAG_Z = 3;
   localparam int FLAG_F = 2;
   localparam int FLAG_L = 1;
   localparam int FLAG_C = 0;
   localparam int FLAG_W = 5;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/alu_rf_pipe_if.sv
// Issue/result bundle between decode (master) and the execute stage (slave).
// No clock inside: clk and reset stay plain ports of the execute stage.
interface alu_rf_pipe_if #(
   parameter int WIDTH = 16,
   parameter int NREGS = 16
);
   localparam int AW = $clog2(NREGS);
   localparam int SW = $clog2(WIDTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [AW-1:0]    src_addr;
   logic [AW-1:0]    dst_addr;
   logic [WIDTH-1:0] imm;
   logic [WIDTH-1:0] pc;
   logic             use_imm;
   logic             use_pc;
   logic [SW-1:0]    shift_amt;
   logic             wr_en;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic [4:0]       flags;

   modport master (
      output in_valid, op, src_addr, dst_addr, imm, pc, use_imm, use_pc, shift_amt, wr_en,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, op, src_addr, dst_addr, imm, pc, use_imm, use_pc, shift_amt, wr_en,
      output in_ready, out_valid, result, flags
   );

endinterface

// File: rtl/alu_rf_regfile.sv
// NREGS x WIDTH register file: two asynchronous read ports, one synchronous write port,
// synchronous reset clears every entry.
module alu_rf_regfile #(
   parameter int WIDTH = 16,
   parameter int NREGS = 16,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_a_i,
   input  logic [AW-1:0]    raddr_b_i,
   output logic [WIDTH-1:0] rdata_a_o,
   output logic [WIDTH-1:0] rdata_b_o
);

   logic [WIDTH-1:0] mem_q [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_rf_pipe.sv
// CR-16 execute stage: register file, ALU, signed shifter, flags, writeback bypass.
// Define ALU_RF_MUL_EN to build the iterative shift-add multiplier for op 8.
module alu_rf_pipe #(
   parameter int WIDTH = 16,
   parameter int NREGS = 16
) (
   input logic          clk,
   input logic          reset,
   alu_rf_pipe_if.slave bus
);
   import alu_rf_pkg::*;

   localparam int AW  = $clog2(NREGS);
   localparam int SW  = $clog2(WIDTH) + 1;
   localparam int MSB = WIDTH - 1;

   logic [WIDTH-1:0]  rf_a, rf_b, reg_a, reg_b, opa, opb;
   logic [WIDTH-1:0]  result_q, result_d;
   logic [FLAG_W-1:0] flags_q, flags_d;
   logic              out_valid_q, out_valid_d;
   logic              wb_en_q, wb_en_d;
   logic [AW-1:0]     wb_addr_q, wb_addr_d;
   logic              accept, is_mul, mul_done;
   logic [WIDTH-1:0]  mul_result;

   alu_rf_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
      .clk       (clk),
      .reset     (reset),
      .we_i      (wb_en_q),
      .waddr_i   (wb_addr_q),
      .wdata_i   (result_q),
      .raddr_a_i (bus.dst_addr),
      .raddr_b_i (bus.src_addr),
      .rdata_a_o (rf_a),
      .rdata_b_o (rf_b)
   );

   // The writeback stage commits at the end of this cycle, so forward result_q per port.
   assign reg_a = (wb_en_q && (wb_addr_q == bus.dst_addr)) ? result_q : rf_a;
   assign reg_b = (wb_en_q && (wb_addr_q == bus.src_addr)) ? result_q : rf_b;
   assign opa   = bus.use_pc  ? bus.pc  : reg_a;
   assign opb   = bus.use_imm ? bus.imm : reg_b;

   assign accept = bus.in_valid && bus.in_ready;

   logic [WIDTH:0]    sum, diff;
   logic              add_ovf, sub_ovf, lt_s;
   logic              sh_neg;
   logic [SW-1:0]     sh_mag;
   logic [WIDTH-1:0]  shl, alu_res;
   logic [FLAG_W-1:0] alu_flags;
   logic              alu_wr_ok;

   assign sum     = {1'b0, opa} + {1'b0, opb};
   assign diff    = {1'b0, opa} - {1'b0, opb};
   assign add_ovf = (opa[MSB] == opb[MSB]) && (sum[MSB] != opa[MSB]);
   assign sub_ovf = (opa[MSB] != opb[MSB]) && (diff[MSB] != opa[MSB]);
   assign lt_s    = $signed(opa) < $signed(opb);

   // Magnitude of -2^(SW-1) wraps to 2^(SW-1) read as unsigned, which is >= WIDTH.
   assign sh_neg = bus.shift_amt[SW-1];
   assign sh_mag = sh_neg ? (~bus.shift_amt + SW'(1)) : bus.shift_amt;

   always_comb begin
      shl = '0;
      if (sh_mag < SW'(WIDTH)) begin
         shl = sh_neg ? (opa >> sh_mag) : (opa << sh_mag);
      end
   end

   always_comb begin
      alu_res   = '0;
      alu_flags = flags_q;
      alu_wr_ok = 1'b0;
      case (bus.op)
         OP_ADD: begin
            alu_res           = sum[MSB:0];
            alu_flags[FLAG_N] = sum[MSB];
            alu_flags[FLAG_Z] = (sum[MSB:0] == '0);
            alu_flags[FLAG_F] = add_ovf;
            alu_flags[FLAG_L] = 1'b0;
            alu_flags[FLAG_C] = sum[WIDTH];
            alu_wr_ok         = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            alu_res           = diff[MSB:0];
            alu_flags[FLAG_N] = (bus.op == OP_CMP) ? lt_s : diff[MSB];
            alu_flags[FLAG_Z] = (diff[MSB:0] == '0);
            alu_flags[FLAG_F] = sub_ovf;
            alu_flags[FLAG_L] = diff[WIDTH];
            alu_flags[FLAG_C] = diff[WIDTH];
            alu_wr_ok         = (bus.op == OP_SUB);
         end
         OP_AND: begin alu_res = opa & opb; alu_wr_ok = 1'b1; end
         OP_OR:  begin alu_res = opa | opb; alu_wr_ok = 1'b1; end
         OP_XOR: begin alu_res = opa ^ opb; alu_wr_ok = 1'b1; end
         OP_MOV: begin alu_res = opb;       alu_wr_ok = 1'b1; end
         OP_LSH: begin alu_res = shl;       alu_wr_ok = 1'b1; end
         default: begin
            alu_res   = '0;
            alu_wr_ok = 1'b0;
         end
      endcase
   end

`ifdef ALU_RF_MUL_EN
   state_e           state_q, state_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_acc_q, mul_acc_d, mul_acc_step;
   logic             mul_wr_q, mul_wr_d;
   logic [AW-1:0]    mul_addr_q, mul_addr_d;

   assign is_mul       = (bus.op == OP_MUL);
   assign bus.in_ready = !reset && (state_q == ST_IDLE);
   assign mul_acc_step = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
   assign mul_result   = mul_acc_step;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      mul_acc_d  = mul_acc_q;
      mul_wr_d   = mul_wr_q;
      mul_addr_d = mul_addr_q;
      mul_done   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept && is_mul) begin
               state_d    = ST_MUL_BUSY;
               cnt_d      = SW'(WIDTH);
               mul_a_d    = opa;
               mul_b_d    = opb;
               mul_acc_d  = '0;
               mul_wr_d   = bus.wr_en;
               mul_addr_d = bus.dst_addr;
            end
         end
         default: begin
            mul_acc_d = mul_acc_step;
            mul_a_d   = mul_a_q << 1;
            mul_b_d   = mul_b_q >> 1;
            cnt_d     = cnt_q - SW'(1);
            // The last step lands in result_q directly as the counter reaches zero.
            if (cnt_q == SW'(1)) begin
               mul_done = 1'b1;
               state_d  = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         mul_acc_q  <= '0;
         mul_wr_q   <= 1'b0;
         mul_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
         mul_acc_q  <= mul_acc_d;
         mul_wr_q   <= mul_wr_d;
         mul_addr_q <= mul_addr_d;
      end
   end
`else
   assign is_mul       = 1'b0;
   assign mul_done     = 1'b0;
   assign mul_result   = '0;
   assign bus.in_ready = !reset;
`endif

   always_comb begin
      result_d    = result_q;
      flags_d     = flags_q;
      out_valid_d = 1'b0;
      wb_en_d     = 1'b0;
      wb_addr_d   = wb_addr_q;
      if (accept && !is_mul) begin
         result_d    = alu_res;
         flags_d     = alu_flags;
         out_valid_d = 1'b1;
         wb_en_d     = bus.wr_en && alu_wr_ok;
         wb_addr_d   = bus.dst_addr;
      end else if (mul_done) begin
         result_d    = mul_result;
         out_valid_d = 1'b1;
`ifdef ALU_RF_MUL_EN
         wb_en_d     = mul_wr_q;
         wb_addr_d   = mul_addr_q;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         wb_en_q     <= 1'b0;
         wb_addr_q   <= '0;
      end else begin
         result_q    <= result_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
         wb_en_q     <= wb_en_d;
         wb_addr_q   <= wb_addr_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_rf_pipe.sv
// Scoreboard bench for alu_rf_pipe: issue pushes expected result/flags, a monitor pops on out_valid.
// Covers the multiplier path when ALU_RF_MUL_EN is defined, otherwise op 8 as reserved.
module tb_alu_rf_pipe;
   import alu_rf_pkg::*;

   localparam int WIDTH = 16;
   localparam int NREGS = 16;
   localparam int AW    = 4;
   localparam int SW    = 5;

   logic clk = 1'b0;
   logic reset;

   alu_rf_pipe_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

   alu_rf_pipe #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic [4:0]  flg;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               $display("txn %-14s result=0x%04h flags=%05b (exp 0x%04h %05b)",
                        e.name, bus.result, bus.flags, e.res, e.flg);
               check({e.name, "_result"}, {16'd0, bus.result}, {16'd0, e.res});
               check({e.name, "_flags"}, {27'd0, bus.flags}, {27'd0, e.flg});
            end
         end
      end
   end

   task automatic issue(input string name, input logic [3:0] op, input logic [AW-1:0] dst,
                        input logic [AW-1:0] src, input logic [15:0] imm, input logic [15:0] pc,
                        input logic ui, input logic up, input logic [SW-1:0] sa, input logic we,
                        input logic [15:0] er, input logic [4:0] ef, input bit push = 1'b1);
      int waited;
      waited        = 0;
      bus.op        = op;
      bus.dst_addr  = dst;
      bus.src_addr  = src;
      bus.imm       = imm;
      bus.pc        = pc;
      bus.use_imm   = ui;
      bus.use_pc    = up;
      bus.shift_amt = sa;
      bus.wr_en     = we;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) check({name, "_ready_timeout"}, {31'd0, bus.in_ready}, 32'd1);
      if (push) exp_q.push_back('{res: er, flg: ef, name: name});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int low_cnt;
      int ov_cnt;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op        = '0;
      bus.dst_addr  = '0;
      bus.src_addr  = '0;
      bus.imm       = '0;
      bus.pc        = '0;
      bus.use_imm   = 1'b0;
      bus.use_pc    = 1'b0;
      bus.shift_amt = '0;
      bus.wr_en     = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset_result", {16'd0, bus.result}, 32'd0);
      check("reset_flags", {27'd0, bus.flags}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Overflowing add with bypass on operand A
      issue("mov_r1",   OP_MOV, 1, 0, 16'h7FFF, 0, 1, 0, 0, 1, 16'h7FFF, 5'b00000);
      issue("add_r1",   OP_ADD, 1, 0, 16'h0001, 0, 1, 0, 0, 1, 16'h8000, 5'b10100);
      // Bypass on both read ports
      issue("mov_r2",   OP_MOV, 2, 0, 16'h0003, 0, 1, 0, 0, 1, 16'h0003, 5'b10100);
      issue("add_r2r2", OP_ADD, 2, 2, 16'h0000, 0, 0, 0, 0, 1, 16'h0006, 5'b00000);
      // Shifter: right, left, magnitude == WIDTH
      issue("mov_r4",   OP_MOV, 4, 0, 16'h8001, 0, 1, 0, 0,        1, 16'h8001, 5'b00000);
      issue("lsh_m1",   OP_LSH, 4, 0, 16'h0000, 0, 0, 0, 5'b11111, 0, 16'h4000, 5'b00000);
      issue("lsh_p4",   OP_LSH, 4, 0, 16'h0000, 0, 0, 0, 5'b00100, 0, 16'h0010, 5'b00000);
      issue("lsh_m16",  OP_LSH, 4, 0, 16'h0000, 0, 0, 0, 5'b10000, 0, 16'h0000, 5'b00000);
      // Compare sets flags but never writes
      issue("mov_r6",   OP_MOV, 6, 0, 16'h0002, 0, 1, 0, 0, 1, 16'h0002, 5'b00000);
      issue("mov_r7",   OP_MOV, 7, 0, 16'h0005, 0, 1, 0, 0, 1, 16'h0005, 5'b00000);
      issue("cmp_r6r7", OP_CMP, 6, 7, 16'h0000, 0, 0, 0, 0, 1, 16'hFFFD, 5'b10011);
      issue("read_r6",  OP_MOV, 0, 6, 16'h0000, 0, 0, 0, 0, 0, 16'h0002, 5'b10011);
      issue("sub_r7r6", OP_SUB, 7, 6, 16'h0000, 0, 0, 0, 0, 0, 16'h0003, 5'b00000);
      issue("sub_zero", OP_SUB, 6, 6, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 5'b01000);
      issue("add_carry",OP_ADD, 0, 0, 16'h0001, 16'hFFFF, 1, 1, 0, 0, 16'h0000, 5'b01001);
      issue("and_pc",   OP_AND, 0, 0, 16'h00FF, 16'h0F0F, 1, 1, 0, 0, 16'h000F, 5'b01001);
      issue("or_r7",    OP_OR,  7, 0, 16'h0030, 0, 1, 0, 0, 0, 16'h0035, 5'b01001);
      issue("xor_r7",   OP_XOR, 7, 0, 16'h0005, 0, 1, 0, 0, 0, 16'h0000, 5'b01001);
      issue("sub_ovf",  OP_SUB, 0, 0, 16'h0001, 16'h8000, 1, 1, 0, 0, 16'h7FFF, 5'b00100);
      // Reserved op: result 0, flags held, no write even with wr_en
      issue("rsvd_12",  4'd12,  7, 0, 16'h1234, 0, 1, 0, 0, 1, 16'h0000, 5'b00100);
      issue("read_r7",  OP_MOV, 0, 7, 16'h0000, 0, 0, 0, 0, 0, 16'h0005, 5'b00100);
      issue("mov_r5",   OP_MOV, 5, 0, 16'h0123, 0, 1, 0, 0, 1, 16'h0123, 5'b00100);

`ifdef ALU_RF_MUL_EN
      issue("mul_r5",   OP_MUL, 5, 0, 16'h0010, 0, 1, 0, 0, 1, 16'h1230, 5'b00100);
      low_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b0) low_cnt++;
      end
      check("mul_ready_low_cycles", low_cnt, 32'd16);
      @(negedge clk);
      check("mul_ready_back", {31'd0, bus.in_ready}, 32'd1);
      check("mul_out_valid_n17", {31'd0, bus.out_valid}, 32'd1);
      @(posedge clk);
      #1;
      issue("read_r5",  OP_MOV, 0, 5, 16'h0000, 0, 0, 0, 0, 0, 16'h1230, 5'b00100);
      // Second multiply is killed by reset in its fifth cycle
      issue("mul_kill", OP_MUL, 5, 0, 16'h0010, 0, 1, 0, 0, 1, 16'h0000, 5'b00000, 1'b0);
`else
      issue("op8_rsvd", OP_MUL, 5, 0, 16'h0010, 0, 1, 0, 0, 1, 16'h0000, 5'b00100);
      @(negedge clk);
      check("op8_ready_stays", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      issue("read_r5",  OP_MOV, 0, 5, 16'h0000, 0, 0, 0, 0, 0, 16'h0123, 5'b00100);
`endif

      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("pulse_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("pulse_ready_after", {31'd0, bus.in_ready}, 32'd1);
      ov_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.out_valid === 1'b1) ov_cnt++;
         @(negedge clk);
      end
      check("pulse_no_out_valid", ov_cnt, 32'd0);
      @(posedge clk);
      #1;
      issue("read_r5_rst", OP_MOV, 0, 5, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 5'b00000);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
